// File: rtl/widen_fifo_pkg.sv
//------------------------------------------------------------------------------
// Module   : widen_fifo_pkg
// Purpose  : Shared types for the widening frame FIFO: beat/word geometry,
//            the stored word layout {last, keep, data}, the lane index type
//            and the write-side state encoding.
// Contents : NARROW_W, RATIO, WIDE_W, LANE_W, WORD_W, lane_t, word_t,
//            wr_state_t, keep_upto()
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package widen_fifo_pkg;

  // Beat and word geometry. The stored word layout is fixed by these values.
  localparam int NARROW_W = 16;
  localparam int RATIO    = 4;
  localparam int WIDE_W   = NARROW_W * RATIO;
  localparam int LANE_W   = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef logic [LANE_W-1:0] lane_t;

  typedef struct packed {
    logic              last;
    logic [RATIO-1:0]  keep;
    logic [WIDE_W-1:0] data;
  } word_t;

  localparam int WORD_W = $bits(word_t);

  // PACK : beats are packed into words and stored.
  // DROP : tail of an overflowed frame is accepted and discarded.
  typedef enum logic [0:0] {
    WR_PACK = 1'b0,
    WR_DROP = 1'b1
  } wr_state_t;

  // Lane-valid mask with bits 0..lane set.
  function automatic logic [RATIO-1:0] keep_upto(input lane_t lane);
    logic [RATIO-1:0] k;
    k = '0;
    for (int i = 0; i < RATIO; i++) begin
      k[i] = (LANE_W'(i) <= lane);
    end
    return k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/widen_fifo_ram.sv
//------------------------------------------------------------------------------
// Module   : widen_fifo_ram
// Purpose  : Simple dual-port RAM, one write port and one synchronous read
//            port (1-cycle latency). Contents are not reset.
// Ports    : clk      in   clock
//            wr_en    in   write enable
//            wr_addr  in   write address (AW bits)
//            wr_word  in   write data (WORD_W bits)
//            rd_en    in   read enable, rd_word updates on the next edge
//            rd_addr  in   read address (AW bits)
//            rd_word  out  read data (WORD_W bits)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module widen_fifo_ram
  import widen_fifo_pkg::*;
#(
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_word
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
    if (rd_en) begin
      rd_word <= mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/widen_frame_fifo.sv
//------------------------------------------------------------------------------
// Module   : widen_frame_fifo
// Purpose  : Store-and-forward frame buffer with RATIO:1 width widening.
//            Narrow beats are packed LSB-first into wide words; only complete
//            (committed) frames are released on the wide port.
// Ports    : clk_i, rst_ni (synchronous, active low)
//            s_data_i/s_valid_i/s_last_i/s_err_i/s_ready_o  narrow input
//            m_data_o/m_keep_o/m_last_o/m_valid_o/m_ready_i wide output
//            used_o   wide words occupied (speculative write minus read ptr)
//            frames_o committed frames not yet fully read
//            ovf_o    sticky, a frame exceeded DEPTH words
// Config   : WIDEN_FIFO_ABORT_EN - when defined, a last beat with s_err_i
//            discards the frame and overflowing frames are dropped whole;
//            otherwise s_err_i is ignored and overflow truncates the frame.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module widen_frame_fifo
  import widen_fifo_pkg::*;
#(
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NARROW_W-1:0] s_data_i,
  input  logic                s_valid_i,
  input  logic                s_last_i,
  input  logic                s_err_i,
  output logic                s_ready_o,
  output logic [WIDE_W-1:0]   m_data_o,
  output logic [RATIO-1:0]    m_keep_o,
  output logic                m_last_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [AW:0]         used_o,
  output logic [AW:0]         frames_o,
  output logic                ovf_o
);

  typedef logic [AW:0] ptr_t;
  localparam ptr_t FULL_CNT = ptr_t'(DEPTH);

  // Write side state
  wr_state_t         state, state_nx;
  lane_t             lane, lane_nx;
  logic [WIDE_W-1:0] pack_data, pack_nx;
  ptr_t              wr_spec, spec_nx;
  ptr_t              wr_commit, commit_nx;
  ptr_t              frames, frames_nx;
  logic              ovf, ovf_nx;
  logic              ready;

  // Read side state
  ptr_t              rd_ptr, rd_nx;
  logic              rd_pend;
  logic              out_valid, skid_valid;
  word_t             out_word, skid_word;

  // Combinational
  logic              accept, flush, fills, overflow, commit;
  logic              ram_we, issue, pop;
  word_t             wword, ram_q;
  logic [WORD_W-1:0] ram_q_raw;
  logic [1:0]        occ_after;

`ifndef WIDEN_FIFO_ABORT_EN
  logic unused_err;
  assign unused_err = s_err_i;
`endif

  //--------------------------------------------------------------------------
  // Write path: lane packing, speculative/commit pointers, overflow handling
  //--------------------------------------------------------------------------
  always_comb begin
    state_nx  = state;
    lane_nx   = lane;
    pack_nx   = pack_data;
    spec_nx   = wr_spec;
    commit_nx = wr_commit;
    ovf_nx    = ovf;
    ram_we    = 1'b0;
    commit    = 1'b0;

    accept = s_valid_i & ready;
    flush  = (lane == lane_t'(RATIO - 1)) | s_last_i;
    fills  = ((wr_spec + ptr_t'(1)) - rd_ptr) == FULL_CNT;
    // The RAM is about to fill with this frame alone: no committed word is
    // left to drain, so the frame can never complete. Force it to end here.
    overflow = flush & ~s_last_i & fills & (wr_commit == rd_ptr);

    // Stored word: held lanes plus the current beat; lanes above it stay zero
    // because pack_data is cleared after every word write.
    wword.data = pack_data;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == lane_t'(i)) begin
        wword.data[i*NARROW_W +: NARROW_W] = s_data_i;
      end
    end
    wword.keep = keep_upto(lane);
    wword.last = s_last_i | overflow;

    case (state)
      WR_PACK: begin
        if (accept) begin
          if (flush) begin
            ram_we  = 1'b1;
            lane_nx = '0;
            pack_nx = '0;
`ifdef WIDEN_FIFO_ABORT_EN
            if (overflow || (s_last_i && s_err_i)) begin
              spec_nx = wr_commit;          // rewind: frame never visible
            end else begin
              spec_nx = wr_spec + ptr_t'(1);
              if (s_last_i) begin
                commit_nx = spec_nx;
                commit    = 1'b1;
              end
            end
`else
            spec_nx = wr_spec + ptr_t'(1);
            if (s_last_i || overflow) begin
              commit_nx = spec_nx;
              commit    = 1'b1;
            end
`endif
            if (overflow) begin
              ovf_nx   = 1'b1;
              state_nx = WR_DROP;
            end
          end else begin
            pack_nx = wword.data;
            lane_nx = lane + lane_t'(1);
          end
        end
      end
      WR_DROP: begin
        if (accept && s_last_i) begin
          state_nx = WR_PACK;
        end
      end
      default: state_nx = WR_PACK;
    endcase
  end

  //--------------------------------------------------------------------------
  // Read path: prefetch into output register + one-entry skid.
  // occ_after counts words that will sit in out/skid after this edge, so a
  // new read is issued only when its data is guaranteed a landing slot.
  //--------------------------------------------------------------------------
  always_comb begin
    pop       = out_valid & m_ready_i;
    occ_after = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(pop);
    issue     = (rd_ptr != wr_commit) && (occ_after < 2'd2);
    rd_nx     = rd_ptr + ptr_t'(issue);

    frames_nx = frames;
    if (commit && !(pop && out_word.last)) begin
      frames_nx = frames + ptr_t'(1);
    end else if (!commit && pop && out_word.last) begin
      frames_nx = frames - ptr_t'(1);
    end
  end

  assign ram_q = word_t'(ram_q_raw);

  widen_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk_i),
    .wr_en   (ram_we),
    .wr_addr (wr_spec[AW-1:0]),
    .wr_word (WORD_W'(wword)),
    .rd_en   (issue),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_word (ram_q_raw)
  );

  //--------------------------------------------------------------------------
  // Registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= WR_PACK;
      lane      <= '0;
      pack_data <= '0;
      wr_spec   <= '0;
      wr_commit <= '0;
      rd_ptr    <= '0;
      frames    <= '0;
      ovf       <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_nx;
      lane      <= lane_nx;
      pack_data <= pack_nx;
      wr_spec   <= spec_nx;
      wr_commit <= commit_nx;
      rd_ptr    <= rd_nx;
      frames    <= frames_nx;
      ovf       <= ovf_nx;
      // Tail of an overflowed frame is always accepted (and discarded).
      ready     <= (state_nx == WR_DROP) || ((spec_nx - rd_nx) != FULL_CNT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_pend    <= 1'b0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_word   <= '0;
      skid_word  <= '0;
    end else begin
      rd_pend <= issue;
      if (!out_valid || pop) begin
        if (skid_valid) begin
          out_word   <= skid_word;
          out_valid  <= 1'b1;
          skid_valid <= rd_pend;
          if (rd_pend) begin
            skid_word <= ram_q;
          end
        end else if (rd_pend) begin
          out_word  <= ram_q;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (rd_pend) begin
        // Output stalled: park the arriving word in the skid entry.
        skid_word  <= ram_q;
        skid_valid <= 1'b1;
      end
    end
  end

  assign s_ready_o = ready;
  assign m_data_o  = out_word.data;
  assign m_keep_o  = out_word.keep;
  assign m_last_o  = out_word.last;
  assign m_valid_o = out_valid;
  assign used_o    = wr_spec - rd_ptr;
  assign frames_o  = frames;
  assign ovf_o     = ovf;

endmodule

`default_nettype wire

// File: tb/tb_widen_frame_fifo.sv
//------------------------------------------------------------------------------
// Module   : tb_widen_frame_fifo
// Purpose  : Directed self-checking bench for widen_frame_fifo
//            (NARROW_W=16, RATIO=4, DEPTH=8). Expectations for both builds of
//            WIDEN_FIFO_ABORT_EN are selected with the same macro.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_widen_frame_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_data;
  logic        s_valid, s_last, s_err, s_ready;
  logic [63:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last, m_valid, m_ready;
  logic [3:0]  used, frames;
  logic        ovf;

  int errors = 0;
  int checks = 0;
  logic [68:0] q[$];

  widen_frame_fifo #(.DEPTH(8)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .s_data_i  (s_data),
    .s_valid_i (s_valid),
    .s_last_i  (s_last),
    .s_err_i   (s_err),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_keep_o  (m_keep),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .used_o    (used),
    .frames_o  (frames),
    .ovf_o     (ovf)
  );

  always #5 clk = ~clk;

  // Record every consumed word as {last, keep, data}.
  always @(posedge clk) begin
    if (rst_n && m_valid && m_ready) q.push_back({m_last, m_keep, m_data});
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l, input logic e);
    int n;
    s_data = d; s_last = l; s_err = e; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 200) begin tick(); n++; end
    if (!s_ready) chk("send_timeout", s_ready, 1'b1);
    tick();
  endtask

  task automatic idle();
    s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0; s_data = '0;
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (q.size() < n && c < budget) begin tick(); c++; end
    chk(tag, q.size(), n);
  endtask

  function automatic logic [68:0] word_at(input int i);
    return (i < q.size()) ? q[i] : 69'h0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; m_ready = 1'b0; idle();
    tick(); tick();
    // Reset state
    chk("rst_ready",  s_ready, 1'b0);
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_used",   used, 4'd0);
    chk("rst_frames", frames, 4'd0);
    chk("rst_ovf",    ovf, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", s_ready, 1'b1);

    // 1. Eight beats -> two full words, latency from commit
    for (int i = 1; i <= 8; i++) send(16'(i), i == 8, 1'b0);
    idle();
    chk("t1_frames_commit", frames, 4'd1);
    chk("t1_used_commit",   used, 4'd2);
    chk("t1_valid_c0",      m_valid, 1'b0);
    tick();
    chk("t1_valid_c1",      m_valid, 1'b0);
    tick();
    chk("t1_valid_c2",      m_valid, 1'b1);
    chk("t1_word0",         {m_last, m_keep, m_data}, {1'b0, 4'hF, 64'h0004_0003_0002_0001});
    tick();
    chk("t1_word0_hold",    {m_valid, m_last, m_keep, m_data}, {1'b1, 1'b0, 4'hF, 64'h0004_0003_0002_0001});
    m_ready = 1'b1;
    tick();
    chk("t1_word1",         {m_valid, m_last, m_keep, m_data}, {1'b1, 1'b1, 4'hF, 64'h0008_0007_0006_0005});
    tick();
    chk("t1_empty_valid",   m_valid, 1'b0);
    chk("t1_empty_frames",  frames, 4'd0);
    chk("t1_empty_used",    used, 4'd0);
    q.delete();

    // 2. Five-beat frame -> partial second word
    for (int i = 1; i <= 5; i++) send(16'(i), i == 5, 1'b0);
    idle();
    wait_words("t2_count", 2, 20);
    chk("t2_word0", word_at(0), {1'b0, 4'hF, 64'h0004_0003_0002_0001});
    chk("t2_word1", word_at(1), {1'b1, 4'b0001, 64'h0000_0000_0000_0005});
    chk("t2_frames", frames, 4'd0);
    q.delete();

    // 3. Three frames queued, ready toggled 1010..
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(16'h0100 + 16'(i), i == 4, 1'b0);
    for (int i = 1; i <= 6; i++) send(16'h0200 + 16'(i), i == 6, 1'b0);
    for (int i = 1; i <= 3; i++) send(16'h0300 + 16'(i), i == 3, 1'b0);
    idle();
    chk("t3_frames3", frames, 4'd3);
    for (int c = 0; c < 60 && q.size() < 4; c++) begin
      m_ready = ~c[0];
      tick();
    end
    m_ready = 1'b0;
    chk("t3_count", q.size(), 4);
    chk("t3_w0", word_at(0), {1'b1, 4'hF,    64'h0104_0103_0102_0101});
    chk("t3_w1", word_at(1), {1'b0, 4'hF,    64'h0204_0203_0202_0201});
    chk("t3_w2", word_at(2), {1'b1, 4'b0011, 64'h0000_0000_0206_0205});
    chk("t3_w3", word_at(3), {1'b1, 4'b0111, 64'h0000_0303_0302_0301});
    chk("t3_frames0", frames, 4'd0);
    repeat (4) tick();
    chk("t3_no_extra", q.size(), 4);
    q.delete();

    // 4. 40-beat frame overflows an 8-word buffer
    m_ready = 1'b1;
    for (int i = 1; i <= 40; i++) send(16'(i), i == 40, 1'b0);
    idle();
    chk("t4_ovf", ovf, 1'b1);
`ifdef WIDEN_FIFO_ABORT_EN
    repeat (10) tick();
    chk("t4_none_out", q.size(), 0);
    chk("t4_frames",   frames, 4'd0);
    chk("t4_used",     used, 4'd0);
`else
    wait_words("t4_count", 8, 50);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t4_w%0d", k), word_at(k),
          {k == 7, 4'hF, 16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)});
    end
    repeat (4) tick();
    chk("t4_no_extra", q.size(), 8);
    chk("t4_frames",   frames, 4'd0);
    chk("t4_used",     used, 4'd0);
`endif
    chk("t4_ready", s_ready, 1'b1);
    q.delete();

    // 5. Frames A, B (error), C
    for (int i = 1; i <= 4; i++) send(16'h0A00 + 16'(i), i == 4, 1'b0);
    for (int i = 1; i <= 3; i++) send(16'h0B00 + 16'(i), i == 3, i == 3);
    for (int i = 1; i <= 2; i++) send(16'h0C00 + 16'(i), i == 2, 1'b0);
    idle();
`ifdef WIDEN_FIFO_ABORT_EN
    wait_words("t5_count", 2, 30);
    chk("t5_A", word_at(0), {1'b1, 4'hF,    64'h0A04_0A03_0A02_0A01});
    chk("t5_C", word_at(1), {1'b1, 4'b0011, 64'h0000_0000_0C02_0C01});
`else
    wait_words("t5_count", 3, 30);
    chk("t5_A", word_at(0), {1'b1, 4'hF,    64'h0A04_0A03_0A02_0A01});
    chk("t5_B", word_at(1), {1'b1, 4'b0111, 64'h0000_0B03_0B02_0B01});
    chk("t5_C", word_at(2), {1'b1, 4'b0011, 64'h0000_0000_0C02_0C01});
`endif
    repeat (4) tick();
    chk("t5_used",   used, 4'd0);
    chk("t5_frames", frames, 4'd0);
    q.delete();

    // 6. Reset mid-frame with a word held on the output
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(16'h5000 + 16'(i), i == 4, 1'b0);
    for (int i = 1; i <= 3; i++) send(16'h7000 + 16'(i), 1'b0, 1'b0);
    idle();
    chk("t6_held", m_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_outs", {s_ready, m_valid, m_last, m_keep, m_data, used, frames, ovf}, 80'h0);
    rst_n = 1'b1;
    tick();
    chk("t6_ready", s_ready, 1'b1);
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(16'h6000 + 16'(i), i == 4, 1'b0);
    idle();
    wait_words("t6_count", 1, 20);
    chk("t6_word", word_at(0), {1'b1, 4'hF, 64'h6004_6003_6002_6001});
    repeat (3) tick();
    chk("t6_no_extra", q.size(), 1);
    chk("t6_used", used, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
